raster_to_blocks: RTL and testbench
===================================

RASTER_TO_BLOCKS -- requirements
Module: raster_to_blocks

Interface
REQ-001 SHALL have parameter N, default 2, meaning pixels per beat; legal values divide 8.
REQ-002 SHALL have parameter X_RES, default 2160, meaning active pixels per line; must be a multiple of 8.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  raster beat present.
REQ-006 SHALL have ports in_data_y, in_data_cr, in_data_cb  input  signed [N-1:0][7:0] each; lane 0 is the lowest x.
REQ-007 SHALL have port in_sol  input  1  marks beat 0 of a line; qualified by in_valid.
REQ-008 SHALL have port in_sof  input  1  marks beat 0 of line 0 of a frame; qualified by in_valid; implies in_sol.
REQ-009 SHALL have port out_valid  output  1  block beat present; no backpressure.
REQ-010 SHALL have ports out_data_y, out_data_cr, out_data_cb  output  signed [N-1:0][7:0] each.
REQ-011 SHALL have ports out_sob, out_eob, out_sof  output  1 each  first beat of block, last beat of block, first beat of frame.
REQ-012 SHALL have port err  output  1  sticky protocol-error flag.

Function
REQ-013 SHALL hold two banks, each 8 lines x X_RES/N words of 3*N*8 bits, as synchronous RAM with 1-cycle read latency.
REQ-014 SHALL write into the write bank only; the write bank SHALL never be the bank being read.
REQ-015 SHALL write at (line, col) on each in_valid beat; col SHALL be forced to 0 on in_sol and then increment per beat.
REQ-016 SHALL complete a line on the beat at col = X_RES/N-1 and increment line; beats after line completion and before the next in_sol SHALL be dropped.
REQ-017 SHALL set line to 0 on in_sof, discard the partial band, and mark the band as frame-start.
REQ-018 SHALL complete the band when line 7 completes: the bank passes to the reader, the write bank toggles, and line resets to 0.
REQ-019 SHALL set err if a band completes while the reader is busy; that band SHALL be dropped and the reader is not disturbed.
REQ-020 SHALL set err on in_sol when the current line is incomplete with col > 0; that line SHALL be restarted.
REQ-021 SHALL use a reader FSM with states IDLE and READ; IDLE goes to READ on band completion, and READ goes to IDLE after the last beat of the last block.
REQ-022 SHALL read blocks bx = 0..X_RES/8-1; within a block it SHALL step rows r = 0..7 and then beats c = 0..8/N-1 (row-major).
REQ-023 SHALL make lane k of beat (r, c) of block bx equal the pixel at x = 8*bx + N*c + k, line r.
REQ-024 SHALL emit 64/N consecutive out_valid beats per block, with no gaps between the blocks of a band.
REQ-025 SHALL assert out_sob on beat 0 of each block and out_eob on beat 64/N-1.
REQ-026 SHALL assert out_sof only on beat 0 of block 0 of a frame-start band.
REQ-027 SHALL present the first out_valid 2 cycles after the band's final input beat is sampled.
REQ-028 SHALL force out_sob, out_eob and out_sof to 0 whenever out_valid = 0; out_data is don't-care then.
REQ-029 SHALL register all outputs.

Reset
REQ-030 SHALL, while rst_n = 0, drive out_valid, out_sob, out_eob, out_sof and err to 0, out_data to 0, the FSM to IDLE, line and col to 0, and the write bank to 0.
REQ-031 SHALL, on reset mid-band, discard all buffered and partial data; RAM contents are not cleared.

Verification
(All scenarios use X_RES=16, N=2, and Y = 16*line + x.)
REQ-032 SHALL cover: a frame of 8 lines starting with in_sof -> 2 blocks of 32 beats; block 0 beat 0 Y = (0,1) with out_sob and out_sof; beat 4 = (16,17); beat 31 = (118,119) with out_eob; block 1 beat 0 = (8,9) with out_sob and no out_sof; beat 31 = (126,127).
REQ-033 SHALL cover: band timing -> first out_valid exactly 2 cycles after line 7 beat 7, then 64 contiguous beats.
REQ-034 SHALL cover: a second band without in_sof -> same data pattern offset by 128 modulo 256, with out_sof never asserted.
REQ-035 SHALL cover: in_sof after 3 lines -> those lines are discarded, the next 8 lines form a band with out_sof, and err stays 0.
REQ-036 SHALL cover: in_sol at col 4 -> err = 1 and the line restarts; a 9th beat on a line is dropped.
REQ-037 SHALL cover: rst_n low during READ -> out_valid = 0 asynchronously, no further output until a new complete band.

Source files
------------

// File: rtl/raster_to_blocks_if.sv
// Raster-in / block-out bus bundle for raster_to_blocks.
// Latency: none, wires only.
// Backpressure: none on either side; the producer drives in_*, the converter drives out_* and err.
interface raster_to_blocks_if #(
  parameter int N = 2
);
  logic                    in_valid;
  logic                    in_sol;
  logic                    in_sof;
  logic signed [N-1:0][7:0] in_data_y;
  logic signed [N-1:0][7:0] in_data_cr;
  logic signed [N-1:0][7:0] in_data_cb;

  logic                    out_valid;
  logic                    out_sob;
  logic                    out_eob;
  logic                    out_sof;
  logic signed [N-1:0][7:0] out_data_y;
  logic signed [N-1:0][7:0] out_data_cr;
  logic signed [N-1:0][7:0] out_data_cb;
  logic                    err;

  // Raster source side
  modport master (
    output in_valid, in_sol, in_sof, in_data_y, in_data_cr, in_data_cb,
    input  out_valid, out_sob, out_eob, out_sof, out_data_y, out_data_cr, out_data_cb, err
  );

  // Converter side
  modport slave (
    input  in_valid, in_sol, in_sof, in_data_y, in_data_cr, in_data_cb,
    output out_valid, out_sob, out_eob, out_sof, out_data_y, out_data_cr, out_data_cb, err
  );
endinterface

// File: rtl/raster_to_blocks.sv
// Converts raster lines into 8x8 blocks via two ping-pong 8-line banks.
// Latency: first block beat 2 cycles after the band's final input beat.
// Backpressure: none; a band finishing while the reader is busy is dropped and flags err.
module raster_to_blocks #(
  parameter int N     = 2,
  parameter int X_RES = 2160
) (
  input  logic           clk,
  input  logic           rst_n,
  raster_to_blocks_if.slave bus
);
  localparam int WPL   = X_RES / N;   // words per line
  localparam int BPR   = 8 / N;       // beats per block row
  localparam int NBLK  = X_RES / 8;   // blocks per band
  localparam int DEPTH = 16 * WPL;    // two banks of 8 lines
  localparam int AW    = $clog2(DEPTH);
  localparam int DW    = 24 * N;
  localparam int CW    = $clog2(WPL + 1);
  localparam int PW    = $clog2(BPR + 1);
  localparam int BW    = $clog2(NBLK + 1);

  typedef enum logic {ST_IDLE, ST_READ} state_t;

  state_t r_state, w_state_nxt;

  // Write-side state
  logic          r_wbank;
  logic [2:0]    r_line;
  logic [CW-1:0] r_col;
  logic          r_drop;      // line finished, ignore beats until next sol
  logic          r_band_sof;  // band being written started a frame
  logic          r_err;

  // Read-side state
  logic          r_rbank;
  logic          r_rd_sof;
  logic [2:0]    r_row;
  logic [PW-1:0] r_c;
  logic [BW-1:0] r_bx;

  // Storage and pipeline
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_dat;
  logic          r_p_vld, r_p_sob, r_p_eob, r_p_sof;

  logic                     r_o_vld, r_o_sob, r_o_eob, r_o_sof;
  logic signed [N-1:0][7:0] r_o_y, r_o_cr, r_o_cb;

  logic          w_sol;
  logic [2:0]    w_line;
  logic [CW-1:0] w_col;
  logic          w_we;
  logic          w_line_end;
  logic          w_band_end;
  logic          w_band_go;
  logic          w_band_sof;
  logic          w_err_sol;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdat;
  logic          w_re;
  logic [AW-1:0] w_raddr;
  logic          w_first;
  logic          w_last_beat;
  logic          w_last_blk;

  // sof implies sol; sol/sof restart the column, sof also restarts the band
  assign w_sol      = bus.in_sol | bus.in_sof;
  assign w_line     = bus.in_sof ? 3'd0 : r_line;
  assign w_col      = w_sol ? '0 : r_col;
  assign w_we       = bus.in_valid & (w_sol | ~r_drop);
  assign w_line_end = w_we & (w_col == CW'(WPL - 1));
  assign w_band_end = w_line_end & (w_line == 3'd7);
  assign w_band_go  = w_band_end & (r_state == ST_IDLE);
  assign w_band_sof = bus.in_sof | r_band_sof;
  assign w_err_sol  = bus.in_valid & w_sol & ~r_drop & (r_col != '0);
  assign w_waddr    = AW'((int'(r_wbank) * 8 + int'(w_line)) * WPL + int'(w_col));
  assign w_wdat     = {bus.in_data_cb, bus.in_data_cr, bus.in_data_y};

  assign w_re        = (r_state == ST_READ);
  assign w_raddr     = AW'((int'(r_rbank) * 8 + int'(r_row)) * WPL + int'(r_bx) * BPR + int'(r_c));
  assign w_first     = (r_row == 3'd0) && (r_c == '0);
  assign w_last_beat = (r_row == 3'd7) && (r_c == PW'(BPR - 1));
  assign w_last_blk  = (r_bx == BW'(NBLK - 1));

  // Line/column tracking, bank hand-over and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbank    <= 1'b0;
      r_line     <= 3'd0;
      r_col      <= '0;
      r_drop     <= 1'b1;
      r_band_sof <= 1'b0;
      r_err      <= 1'b0;
      r_rbank    <= 1'b0;
      r_rd_sof   <= 1'b0;
    end else begin
      if (w_err_sol || (w_band_end && !w_band_go)) begin
        r_err <= 1'b1;
      end
      if (w_we) begin
        if (w_line_end) begin
          r_col  <= '0;
          r_drop <= 1'b1;
          if (w_band_end) begin
            r_line     <= 3'd0;
            r_band_sof <= 1'b0;
            if (w_band_go) begin
              r_wbank  <= ~r_wbank;
              r_rbank  <= r_wbank;
              r_rd_sof <= w_band_sof;
            end
          end else begin
            r_line     <= w_line + 3'd1;
            r_band_sof <= w_band_sof;
          end
        end else begin
          r_col      <= w_col + CW'(1);
          r_drop     <= 1'b0;
          r_line     <= w_line;
          r_band_sof <= w_band_sof;
        end
      end
    end
  end

  // Band RAM: one write port (write bank), one registered read port (read bank)
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdat;
    end
    if (w_re) begin
      r_rd_dat <= r_mem[w_raddr];
    end
  end

  // Reader state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Reader next state: a completed band starts READ, last beat of last block ends it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_band_go) w_state_nxt = ST_READ;
      ST_READ: if (w_last_beat && w_last_blk) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Block scan counters (column-beat inner, row, then block) and flags aligned with RAM data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row   <= 3'd0;
      r_c     <= '0;
      r_bx    <= '0;
      r_p_vld <= 1'b0;
      r_p_sob <= 1'b0;
      r_p_eob <= 1'b0;
      r_p_sof <= 1'b0;
    end else begin
      r_p_vld <= w_re;
      r_p_sob <= w_re & w_first;
      r_p_eob <= w_re & w_last_beat;
      r_p_sof <= w_re & w_first & (r_bx == '0) & r_rd_sof;
      if (w_re) begin
        if (r_c == PW'(BPR - 1)) begin
          r_c <= '0;
          if (r_row == 3'd7) begin
            r_row <= 3'd0;
            r_bx  <= w_last_blk ? '0 : r_bx + BW'(1);
          end else begin
            r_row <= r_row + 3'd1;
          end
        end else begin
          r_c <= r_c + PW'(1);
        end
      end
    end
  end

  // Output register stage; data only updates on valid beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o_vld <= 1'b0;
      r_o_sob <= 1'b0;
      r_o_eob <= 1'b0;
      r_o_sof <= 1'b0;
      r_o_y   <= '0;
      r_o_cr  <= '0;
      r_o_cb  <= '0;
    end else begin
      r_o_vld <= r_p_vld;
      r_o_sob <= r_p_sob;
      r_o_eob <= r_p_eob;
      r_o_sof <= r_p_sof;
      if (r_p_vld) begin
        r_o_y  <= r_rd_dat[8*N-1:0];
        r_o_cr <= r_rd_dat[16*N-1:8*N];
        r_o_cb <= r_rd_dat[24*N-1:16*N];
      end
    end
  end

  assign bus.out_valid   = r_o_vld;
  assign bus.out_sob     = r_o_sob;
  assign bus.out_eob     = r_o_eob;
  assign bus.out_sof     = r_o_sof;
  assign bus.out_data_y  = r_o_y;
  assign bus.out_data_cr = r_o_cr;
  assign bus.out_data_cb = r_o_cb;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_raster_to_blocks.sv
// Scoreboard bench for raster_to_blocks with X_RES=16, N=2.
// Stimulus pushes expected block beats and start cycles; a negedge monitor pops and compares.
// Pixel pattern: Y = base + 16*line + x, Cr = ~Y, Cb = Y ^ 0xA5.
module tb_raster_to_blocks;
  localparam int N     = 2;
  localparam int X_RES = 16;
  localparam int WPL   = X_RES / N;

  typedef struct packed {
    logic [7:0] y0, y1, cr0, cr1, cb0, cb1;
    logic       sob, eob, sof;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  raster_to_blocks_if #(.N(N)) bus();

  raster_to_blocks #(.N(N), .X_RES(X_RES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t exp_q[$];
  int    start_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    vld_seen = 0;
  bit    prev_vld = 1'b0;
  bit    cap_en = 1'b0;
  int    cap_n = 0;
  logic [15:0] cap_y [64];
  logic [2:0]  cap_f [64];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] py(input int base, input int line, input int x);
    return 8'(base + 16 * line + x);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Expected beats of one band, in block / row / column-beat order
  task automatic push_band(input int base, input bit sof);
    beat_t e;
    for (int bx = 0; bx < X_RES / 8; bx++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8 / N; c++) begin
          int x;
          x = 8 * bx + N * c;
          e.y0  = py(base, r, x);
          e.y1  = py(base, r, x + 1);
          e.cr0 = ~e.y0;
          e.cr1 = ~e.y1;
          e.cb0 = e.y0 ^ 8'hA5;
          e.cb1 = e.y1 ^ 8'hA5;
          e.sob = (r == 0) && (c == 0);
          e.eob = (r == 7) && (c == 8 / N - 1);
          e.sof = sof && (bx == 0) && e.sob;
          exp_q.push_back(e);
        end
  endtask

  task automatic drive_beat(input int line, input int col, input bit sol, input bit sof, input int base);
    logic [7:0] y0, y1;
    y0 = py(base, line, N * col);
    y1 = py(base, line, N * col + 1);
    bus.in_valid      = 1'b1;
    bus.in_sol        = sol;
    bus.in_sof        = sof;
    bus.in_data_y[0]  = y0;
    bus.in_data_y[1]  = y1;
    bus.in_data_cr[0] = ~y0;
    bus.in_data_cr[1] = ~y1;
    bus.in_data_cb[0] = y0 ^ 8'hA5;
    bus.in_data_cb[1] = y1 ^ 8'hA5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sol   = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_line(input int line, input int base, input bit sof);
    for (int col = 0; col < WPL; col++)
      drive_beat(line, col, col == 0, sof && (col == 0), base);
  endtask

  // One band of 8 lines; optional stray 9th beat after extra_line, optional aborted start of glitch_line
  task automatic send_band(input int base, input bit sof, input int extra_line, input int glitch_line);
    push_band(base, sof);
    for (int l = 0; l < 8; l++) begin
      if (l == glitch_line)
        for (int col = 0; col < 4; col++) drive_beat(l, col, col == 0, 1'b0, 77);
      send_line(l, base, sof && (l == 0));
      if (l == extra_line) drive_beat(l, 0, 1'b0, 1'b0, 99);
    end
    start_q.push_back(cyc + 2);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && start_q.size() == 0) break;
      @(posedge clk);
    end
    checks++;
    if (exp_q.size() != 0 || start_q.size() != 0) begin
      failures++;
      $display("FAIL %s drain_timeout beats_left=%0d starts_left=%0d required=0", name, exp_q.size(), start_q.size());
      exp_q.delete();
      start_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: band start timing, beat contents and idle flags
  always @(negedge clk) begin
    beat_t g, e;
    if (rst_n) begin
      if (bus.out_valid) begin
        vld_seen++;
        if (!prev_vld) begin
          checks++;
          if (start_q.size() == 0) begin
            failures++;
            $display("FAIL band_start unexpected at cycle %0d", cyc);
          end else begin
            int s;
            s = start_q.pop_front();
            if (s != cyc) begin
              failures++;
              $display("FAIL band_start got_cycle=%0d expected_cycle=%0d", cyc, s);
            end
          end
        end
        g = {bus.out_data_y[0], bus.out_data_y[1], bus.out_data_cr[0], bus.out_data_cr[1],
             bus.out_data_cb[0], bus.out_data_cb[1], bus.out_sob, bus.out_eob, bus.out_sof};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL beat unexpected got=%h", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            failures++;
            $display("FAIL beat got=%h expected=%h", g, e);
          end
        end
        if (cap_en && cap_n < 64) begin
          cap_y[cap_n] = {bus.out_data_y[0], bus.out_data_y[1]};
          cap_f[cap_n] = {bus.out_sob, bus.out_eob, bus.out_sof};
          cap_n++;
        end
      end else begin
        checks++;
        if (bus.out_sob || bus.out_eob || bus.out_sof) begin
          failures++;
          $display("FAIL idle_flags got=%b%b%b expected=000", bus.out_sob, bus.out_eob, bus.out_sof);
        end
      end
      prev_vld = bus.out_valid;
    end else begin
      prev_vld = 1'b0;
    end
  end

  initial begin
    int seen0;
    bus.in_valid   = 1'b0;
    bus.in_sol     = 1'b0;
    bus.in_sof     = 1'b0;
    bus.in_data_y  = '0;
    bus.in_data_cr = '0;
    bus.in_data_cb = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sob",   32'(bus.out_sob),   32'd0);
    chk("rst_eob",   32'(bus.out_eob),   32'd0);
    chk("rst_sof",   32'(bus.out_sof),   32'd0);
    chk("rst_err",   32'(bus.err),       32'd0);
    chk("rst_y",     32'(bus.out_data_y),  32'd0);
    chk("rst_cr",    32'(bus.out_data_cr), 32'd0);
    chk("rst_cb",    32'(bus.out_data_cb), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame-start band, with hand-computed beat checks
    cap_en = 1'b1;
    send_band(0, 1'b1, -1, -1);
    wait_drain("band_sof");
    cap_en = 1'b0;
    chk("cap_count",     32'(cap_n), 32'd64);
    chk("b0_beat0_y",    32'(cap_y[0]),  32'h0001);
    chk("b0_beat0_flag", 32'(cap_f[0]),  32'b101);
    chk("b0_beat4_y",    32'(cap_y[4]),  32'h1011);
    chk("b0_beat31_y",   32'(cap_y[31]), 32'h7677);
    chk("b0_beat31_flag",32'(cap_f[31]), 32'b010);
    chk("b1_beat0_y",    32'(cap_y[32]), 32'h0809);
    chk("b1_beat0_flag", 32'(cap_f[32]), 32'b100);
    chk("b1_beat31_y",   32'(cap_y[63]), 32'h7E7F);

    // Second band without sof: pattern offset by 128
    send_band(128, 1'b0, -1, -1);
    wait_drain("band_nosof");

    // sof after 3 lines discards them without error
    for (int l = 0; l < 3; l++) send_line(l, 200, l == 0);
    send_band(32, 1'b1, -1, -1);
    wait_drain("band_resof");
    chk("err_after_resof", 32'(bus.err), 32'd0);

    // Stray 9th beat is dropped
    send_band(16, 1'b0, 2, -1);
    wait_drain("band_9th");
    chk("err_after_9th", 32'(bus.err), 32'd0);

    // sol at col 4 restarts the line and flags err
    send_band(48, 1'b0, -1, 3);
    wait_drain("band_restart");
    chk("err_after_restart", 32'(bus.err), 32'd1);

    // Reset while the reader is streaming
    send_band(0, 1'b1, -1, -1);
    repeat (10) @(posedge clk);
    #1;
    chk("valid_before_reset", 32'(bus.out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("valid_async_reset", 32'(bus.out_valid), 32'd0);
    chk("err_async_reset",   32'(bus.err),       32'd0);
    exp_q.delete();
    start_q.delete();
    repeat (3) @(negedge clk);
    chk("valid_in_reset", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    seen0 = vld_seen;
    repeat (100) @(posedge clk);
    #1;
    chk("no_output_after_reset", 32'(vld_seen - seen0), 32'd0);

    // A fresh complete band after reset
    send_band(80, 1'b1, -1, -1);
    wait_drain("band_after_reset");
    chk("err_final", 32'(bus.err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
